// File: rtl/timer_arbiter_if.sv
// Request/grant bundle between the requesters and the shared interval timer.
// The master side drives the requests; the slave side is the arbiter.
interface timer_arbiter_if #(
    parameter int NREQ = 4,
    parameter int IW   = 2,
    parameter int CW   = 8
);
    logic [NREQ-1:0]    REQ;
    logic [NREQ*CW-1:0] LOAD_VAL;
    logic               EN;
    logic [NREQ-1:0]    GNT;
    logic [NREQ-1:0]    DONE;
    logic               BUSY;
    logic [IW-1:0]      OWNER;
    logic [CW-1:0]      COUNT;

    modport master (output REQ, LOAD_VAL, EN, input GNT, DONE, BUSY, OWNER, COUNT);
    modport slave  (input REQ, LOAD_VAL, EN, output GNT, DONE, BUSY, OWNER, COUNT);
endinterface

// File: rtl/timer_arbiter.sv
// Round-robin owner of one shared down-counter: grant, load, count to zero,
// pulse DONE for one cycle, then release. All outputs come straight from flops.
module timer_arbiter #(
    parameter int NREQ = 4,
    parameter int IW   = 2,
    parameter int CW   = 8
) (
    input logic           CLK,
    input logic           RST_N,
    timer_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, RELEASE} state_t;

    state_t                  state, state_nx;
    logic [NREQ-1:0]         gnt, gnt_nx, done, done_nx;
    logic                    busy, busy_nx;
    logic [IW-1:0]           owner, owner_nx, ptr, ptr_nx;
    logic [CW-1:0]           count, count_nx;
    logic [NREQ-1:0][CW-1:0] load;
    logic [IW-1:0]           win;
    logic                    win_vld;

    for (genvar i = 0; i < NREQ; i++) begin : g_slice
        assign load[i] = bus.LOAD_VAL[i*CW +: CW];
    end

    // Scan from the far end so the candidate nearest ptr+1 is written last and wins.
    always_comb begin
        win     = '0;
        win_vld = 1'b0;
        for (int k = NREQ; k >= 1; k--) begin
            if (bus.REQ[(int'(ptr) + k) % NREQ]) begin
                win     = IW'((int'(ptr) + k) % NREQ);
                win_vld = 1'b1;
            end
        end
    end

    always_comb begin
        state_nx = state;
        gnt_nx   = gnt;
        done_nx  = '0;
        busy_nx  = busy;
        owner_nx = owner;
        count_nx = count;
        ptr_nx   = ptr;
        case (state)
            IDLE: begin
                if (win_vld) begin
                    state_nx     = RUN;
                    gnt_nx       = '0;
                    gnt_nx[win]  = 1'b1;
                    owner_nx     = win;
                    count_nx     = load[win];
                    ptr_nx       = win;
                    busy_nx      = 1'b1;
                end
            end
            RUN: begin
                // A dropped request beats expiry: the owner gave up, so no DONE.
                if (!bus.REQ[owner]) begin
                    state_nx = IDLE;
                    gnt_nx   = '0;
                    busy_nx  = 1'b0;
                end else if (count == '0) begin
                    state_nx       = RELEASE;
                    gnt_nx         = '0;
                    done_nx[owner] = 1'b1;
                end else if (bus.EN) begin
                    count_nx = count - CW'(1);
                end
            end
            RELEASE: begin
                state_nx = IDLE;
                busy_nx  = 1'b0;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
            gnt   <= '0;
            done  <= '0;
            busy  <= 1'b0;
            owner <= '0;
            count <= '0;
            ptr   <= IW'(NREQ - 1);
        end else begin
            state <= state_nx;
            gnt   <= gnt_nx;
            done  <= done_nx;
            busy  <= busy_nx;
            owner <= owner_nx;
            count <= count_nx;
            ptr   <= ptr_nx;
        end
    end

    assign bus.GNT   = gnt;
    assign bus.DONE  = done;
    assign bus.BUSY  = busy;
    assign bus.OWNER = owner;
    assign bus.COUNT = count;
endmodule

// File: tb/tb_timer_arbiter.sv
// Self-checking bench for timer_arbiter: vector table, directed corner sequences,
// and random traffic against an ownership/countdown reference model.
module tb_timer_arbiter;
    logic CLK, RST_N;
    int   passed = 0, total = 0;

    timer_arbiter_if #(.NREQ(4), .IW(2), .CW(8)) bus ();
    timer_arbiter #(.NREQ(4), .IW(2), .CW(8)) dut (.CLK(CLK), .RST_N(RST_N), .bus(bus));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference model: who holds the timer, what is left, whether DONE is showing.
    int m_act, m_rel, m_own, m_cnt, m_ptr;

    task automatic model_reset();
        m_act = 0; m_rel = 0; m_own = 0; m_cnt = 0; m_ptr = 3;
    endtask

    task automatic model_step();
        if (m_rel != 0) begin
            m_rel = 0;
        end else if (m_act != 0) begin
            if (!bus.REQ[m_own]) m_act = 0;
            else if (m_cnt == 0) begin m_act = 0; m_rel = 1; end
            else if (bus.EN) m_cnt = m_cnt - 1;
        end else if (bus.REQ != 4'b0) begin
            for (int k = 1; k <= 4; k++) begin
                if (bus.REQ[(m_ptr + k) % 4]) begin m_own = (m_ptr + k) % 4; break; end
            end
            m_act = 1;
            m_cnt = int'(bus.LOAD_VAL[m_own*8 +: 8]);
            m_ptr = m_own;
        end
    endtask

    function automatic logic [18:0] model_exp();
        logic [3:0] g, d;
        g = (m_act != 0) ? 4'(1 << m_own) : 4'b0;
        d = (m_rel != 0) ? 4'(1 << m_own) : 4'b0;
        return {g, d, 1'(m_act | m_rel), 2'(m_own), 8'(m_cnt)};
    endfunction

    function automatic logic [18:0] dut_vec();
        return {bus.GNT, bus.DONE, bus.BUSY, bus.OWNER, bus.COUNT};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge CLK);
        model_step();
        #1;
        check("model", 32'(dut_vec()), 32'(model_exp()));
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        bus.REQ = '0; bus.EN = 1'b1; bus.LOAD_VAL = '0;
        #1 model_reset();
        repeat (2) @(posedge CLK);
        @(negedge CLK) RST_N = 1'b1;
    endtask

    typedef struct {
        logic [3:0]  req;
        logic        en;
        logic [31:0] load;
        logic [3:0]  gnt;
        logic [3:0]  done;
        logic        busy;
        logic [7:0]  count;
    } vec_t;
    vec_t tbl[7];

    int exp_order[5] = '{0, 1, 2, 3, 0};
    int order[$];
    int dcnt, g_cyc, d_cyc, cyc, found, gcnt;
    logic [3:0] prev_gnt;

    initial begin
        tbl[0] = '{4'b0001, 1'b1, 32'h3, 4'b0001, 4'b0000, 1'b1, 8'd3};
        tbl[1] = '{4'b0001, 1'b1, 32'h3, 4'b0001, 4'b0000, 1'b1, 8'd2};
        tbl[2] = '{4'b0001, 1'b1, 32'h3, 4'b0001, 4'b0000, 1'b1, 8'd1};
        tbl[3] = '{4'b0001, 1'b1, 32'h3, 4'b0001, 4'b0000, 1'b1, 8'd0};
        tbl[4] = '{4'b0001, 1'b1, 32'h3, 4'b0000, 4'b0001, 1'b1, 8'd0};
        tbl[5] = '{4'b0000, 1'b1, 32'h3, 4'b0000, 4'b0000, 1'b0, 8'd0};
        tbl[6] = '{4'b0000, 1'b1, 32'h3, 4'b0000, 4'b0000, 1'b0, 8'd0};

        // Reset state
        RST_N = 1'b0; bus.REQ = '0; bus.EN = 1'b1; bus.LOAD_VAL = '0;
        #2 model_reset();
        check("reset_state", 32'(dut_vec()), 32'h0);
        @(negedge CLK) RST_N = 1'b1;

        // Single requester, load 3
        for (int i = 0; i < 7; i++) begin
            bus.REQ = tbl[i].req; bus.EN = tbl[i].en; bus.LOAD_VAL = tbl[i].load;
            step();
            check($sformatf("tbl%0d", i), 32'({bus.GNT, bus.DONE, bus.BUSY, bus.COUNT}),
                  32'({tbl[i].gnt, tbl[i].done, tbl[i].busy, tbl[i].count}));
        end

        // All requesting, zero loads: round-robin order, one DONE per tenure
        do_reset();
        bus.REQ = 4'b1111; bus.LOAD_VAL = '0; bus.EN = 1'b1;
        order.delete(); dcnt = 0; prev_gnt = '0;
        for (int c = 0; c < 40 && order.size() < 5; c++) begin
            step();
            if (bus.DONE != 4'b0) dcnt++;
            if (prev_gnt == 4'b0 && bus.GNT != 4'b0) begin
                if (order.size() > 0) check("rr_one_done", 32'(dcnt), 32'd1);
                dcnt = 0;
                order.push_back(int'(bus.OWNER));
            end
            prev_gnt = bus.GNT;
        end
        check("rr_count", 32'(order.size()), 32'd5);
        for (int i = 0; i < 5 && i < order.size(); i++)
            check($sformatf("rr_order%0d", i), 32'(order[i]), 32'(exp_order[i]));

        // EN freeze delays DONE by exactly the frozen cycles
        do_reset();
        bus.REQ = 4'b0100; bus.LOAD_VAL = 32'h0005_0000; bus.EN = 1'b1;
        found = 0; cyc = 0; g_cyc = 0; d_cyc = 0;
        while (found == 0 && cyc < 20) begin step(); cyc++; if (bus.GNT != 4'b0) begin found = 1; g_cyc = cyc; end end
        check("freeze_grant", 32'(found), 32'd1);
        repeat (2) begin step(); cyc++; end
        bus.EN = 1'b0;
        repeat (3) begin step(); cyc++; end
        check("freeze_hold", 32'(bus.COUNT), 32'd3);
        bus.EN = 1'b1;
        found = 0;
        while (found == 0 && cyc < 60) begin step(); cyc++; if (bus.DONE != 4'b0) begin found = 1; d_cyc = cyc; end end
        check("freeze_done_seen", 32'(found), 32'd1);
        check("freeze_delay", 32'(d_cyc - g_cyc), 32'd9);
        bus.REQ = '0; step(); step();

        // Abort at COUNT=6, pending requester 3 takes over
        do_reset();
        bus.REQ = 4'b1010; bus.LOAD_VAL = 32'h0400_0A00; bus.EN = 1'b1;
        found = 0;
        for (int c = 0; c < 30 && found == 0; c++) begin
            step();
            if (bus.GNT == 4'b0010 && bus.COUNT == 8'd6) found = 1;
        end
        check("abort_reach6", 32'(found), 32'd1);
        bus.REQ = 4'b1000;
        step();
        check("abort_gnt_dn", 32'({bus.GNT, bus.DONE}), 32'h0);
        step();
        check("abort_next", 32'(bus.GNT), 32'b1000);
        bus.REQ = '0;
        repeat (8) step();

        // Reset mid-run at COUNT=4
        do_reset();
        bus.REQ = 4'b0001; bus.LOAD_VAL = 32'h9; bus.EN = 1'b1;
        found = 0;
        for (int c = 0; c < 30 && found == 0; c++) begin
            step();
            if (bus.BUSY && bus.COUNT == 8'd4) found = 1;
        end
        check("rst_reach4", 32'(found), 32'd1);
        #1 RST_N = 1'b0;
        #1 model_reset();
        check("rst_mid", 32'({bus.GNT, bus.DONE, bus.BUSY, bus.COUNT}), 32'h0);
        bus.REQ = 4'b1000;
        @(negedge CLK) RST_N = 1'b1;
        step();
        check("rst_regrant", 32'(bus.GNT), 32'b1000);
        bus.REQ = '0;
        repeat (3) step();

        // Full-scale load 255
        do_reset();
        bus.REQ = 4'b0001; bus.LOAD_VAL = 32'hFF; bus.EN = 1'b1;
        gcnt = 0; dcnt = 0; found = 0;
        for (int c = 0; c < 300 && found == 0; c++) begin
            step();
            if (bus.GNT != 4'b0) gcnt++;
            if (bus.DONE != 4'b0) begin dcnt++; bus.REQ = '0; end
            if (dcnt > 0 && !bus.BUSY) found = 1;
        end
        check("max_finish", 32'(found), 32'd1);
        check("max_gnt_cycles", 32'(gcnt), 32'd256);
        check("max_done", 32'(dcnt), 32'd1);

        // Random traffic against the model
        do_reset();
        for (int c = 0; c < 600; c++) begin
            bus.REQ      = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
            bus.EN       = ($urandom_range(0, 3) != 0);
            bus.LOAD_VAL = {8'($urandom_range(0, 6)), 8'($urandom_range(0, 6)),
                            8'($urandom_range(0, 6)), 8'($urandom_range(0, 6))};
            if ($urandom_range(0, 7) != 0 && m_act != 0) bus.REQ[m_own] = 1'b1;
            step();
            check("onehot", 32'($countones(bus.GNT) <= 1 && $countones(bus.DONE) <= 1
                                && (bus.GNT & bus.DONE) == 4'b0), 32'd1);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
